// File: rtl/instruction_register_if.sv
// Bus bundle for the instruction register: fetch-side load and decoded outputs.
// Valid rides along only when IR_VALID_EN is defined.
interface instruction_register_if;
  logic [15:0] DataIn;
  logic        InstWrite;
  logic [15:0] DataOut;
  logic [3:0]  Op;
  logic [3:0]  Rd;
  logic [3:0]  Rm;
  logic [7:0]  Imm;
  logic        MoveA;
  logic        MoveB;
  logic        CLRA;
  logic        CLRB;
`ifdef IR_VALID_EN
  logic        Valid;
`endif

  modport master (
    output DataIn, InstWrite,
    input  DataOut, Op, Rd, Rm, Imm,
    input  MoveA, MoveB, CLRA, CLRB
`ifdef IR_VALID_EN
    , input Valid
`endif
  );

  modport slave (
    input  DataIn, InstWrite,
    output DataOut, Op, Rd, Rm, Imm,
    output MoveA, MoveB, CLRA, CLRB
`ifdef IR_VALID_EN
    , output Valid
`endif
  );
endinterface

// File: rtl/instruction_register.sv
// 16-bit instruction register with field slicing and move/clear strobe decode.
// Optional macro IR_VALID_EN adds a Valid flag that gates the strobes.
module instruction_register #(
  parameter logic [3:0] MOVEA_OP = 4'hC,
  parameter logic [3:0] MOVEB_OP = 4'hD,
  parameter logic [3:0] CLRA_OP  = 4'hE,
  parameter logic [3:0] CLRB_OP  = 4'hF
) (
  input logic CLK,
  input logic Reset,
  instruction_register_if.slave bus
);

  logic [15:0] ir;
  logic        strobeEn;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      ir <= 16'h0000;
    end else if (bus.InstWrite) begin
      ir <= bus.DataIn;
    end
  end

`ifdef IR_VALID_EN
  logic validQ;

  // Sticky until reset: set by the first load after reset.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      validQ <= 1'b0;
    end else if (bus.InstWrite) begin
      validQ <= 1'b1;
    end
  end

  assign bus.Valid = validQ;
  assign strobeEn  = validQ;
`else
  assign strobeEn  = 1'b1;
`endif

  assign bus.DataOut = ir;
  assign bus.Op      = ir[15:12];
  assign bus.Rd      = ir[11:8];
  assign bus.Rm      = ir[7:4];
  assign bus.Imm     = ir[7:0];

  assign bus.MoveA = strobeEn && (ir[15:12] == MOVEA_OP);
  assign bus.MoveB = strobeEn && (ir[15:12] == MOVEB_OP);
  assign bus.CLRA  = strobeEn && (ir[15:12] == CLRA_OP);
  assign bus.CLRB  = strobeEn && (ir[15:12] == CLRB_OP);

endmodule

// File: tb/tb_instruction_register.sv
// Directed bench for instruction_register: reset, load, hold, reload,
// non-strobe opcodes and reset-vs-write priority.
module tb_instruction_register;

  logic CLK;
  logic Reset;
  int   nTests;
  int   nFail;

  instruction_register_if bus ();

  instruction_register dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // {DataOut, Op, Rd, Rm, Imm, MoveA, MoveB, CLRA, CLRB}
  logic [39:0] obs;
  assign obs = {bus.DataOut, bus.Op, bus.Rd, bus.Rm, bus.Imm,
                bus.MoveA, bus.MoveB, bus.CLRA, bus.CLRB};

  task automatic stepEdge(input logic rst, input logic wr,
                          input logic [15:0] din);
    Reset         = rst;
    bus.InstWrite = wr;
    bus.DataIn    = din;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 2; i++) begin
      stepEdge(1'b1, 1'b1, 16'hFFFF);
      nTests++;
      if (obs !== {16'h0000, 4'h0, 4'h0, 4'h0, 8'h00, 4'b0000}) begin
        nFail++;
        $display("FAIL reset[%0d] got %h want %h", i, obs,
                 {16'h0000, 4'h0, 4'h0, 4'h0, 8'h00, 4'b0000});
      end
    end
  endtask

  task automatic test_load;
    stepEdge(1'b0, 1'b1, 16'hF0F0);
    nTests++;
    if (obs !== {16'hF0F0, 4'hF, 4'h0, 4'hF, 8'hF0, 4'b0001}) begin
      nFail++;
      $display("FAIL load_F0F0 got %h want %h", obs,
               {16'hF0F0, 4'hF, 4'h0, 4'hF, 8'hF0, 4'b0001});
    end
  endtask

  task automatic test_hold;
    for (int i = 0; i < 5; i++) begin
      stepEdge(1'b0, 1'b0, (i % 2 == 0) ? 16'hCCCA : 16'h1234);
      nTests++;
      if (obs !== {16'hF0F0, 4'hF, 4'h0, 4'hF, 8'hF0, 4'b0001}) begin
        nFail++;
        $display("FAIL hold[%0d] got %h want %h", i, obs,
                 {16'hF0F0, 4'hF, 4'h0, 4'hF, 8'hF0, 4'b0001});
      end
    end
  endtask

  task automatic test_back_to_back;
    stepEdge(1'b0, 1'b1, 16'hCCCA);
    nTests++;
    if (obs !== {16'hCCCA, 4'hC, 4'hC, 4'hC, 8'hCA, 4'b1000}) begin
      nFail++;
      $display("FAIL load_CCCA got %h want %h", obs,
               {16'hCCCA, 4'hC, 4'hC, 4'hC, 8'hCA, 4'b1000});
    end
    stepEdge(1'b0, 1'b1, 16'hD123);
    nTests++;
    if (obs !== {16'hD123, 4'hD, 4'h1, 4'h2, 8'h23, 4'b0100}) begin
      nFail++;
      $display("FAIL load_D123 got %h want %h", obs,
               {16'hD123, 4'hD, 4'h1, 4'h2, 8'h23, 4'b0100});
    end
    stepEdge(1'b0, 1'b1, 16'hE000);
    nTests++;
    if (obs !== {16'hE000, 4'hE, 4'h0, 4'h0, 8'h00, 4'b0010}) begin
      nFail++;
      $display("FAIL load_E000 got %h want %h", obs,
               {16'hE000, 4'hE, 4'h0, 4'h0, 8'h00, 4'b0010});
    end
  endtask

  task automatic test_non_strobe;
    stepEdge(1'b0, 1'b1, 16'h5A3C);
    nTests++;
    if (obs !== {16'h5A3C, 4'h5, 4'hA, 4'h3, 8'h3C, 4'b0000}) begin
      nFail++;
      $display("FAIL load_5A3C got %h want %h", obs,
               {16'h5A3C, 4'h5, 4'hA, 4'h3, 8'h3C, 4'b0000});
    end
  endtask

  task automatic test_reset_vs_write;
    stepEdge(1'b0, 1'b1, 16'hC000);
    stepEdge(1'b1, 1'b1, 16'hC000);
    nTests++;
    if (obs !== {16'h0000, 4'h0, 4'h0, 4'h0, 8'h00, 4'b0000}) begin
      nFail++;
      $display("FAIL reset_wins got %h want %h", obs,
               {16'h0000, 4'h0, 4'h0, 4'h0, 8'h00, 4'b0000});
    end
`ifdef IR_VALID_EN
    nTests++;
    if (bus.Valid !== 1'b0) begin
      nFail++;
      $display("FAIL valid_after_reset got %b want 0", bus.Valid);
    end
`endif
    stepEdge(1'b0, 1'b0, 16'hC000);
    nTests++;
    if (obs !== {16'h0000, 4'h0, 4'h0, 4'h0, 8'h00, 4'b0000}) begin
      nFail++;
      $display("FAIL stay_zero got %h want %h", obs,
               {16'h0000, 4'h0, 4'h0, 4'h0, 8'h00, 4'b0000});
    end
`ifdef IR_VALID_EN
    nTests++;
    if (bus.Valid !== 1'b0) begin
      nFail++;
      $display("FAIL valid_no_write got %b want 0", bus.Valid);
    end
`endif
    stepEdge(1'b0, 1'b1, 16'hC000);
    nTests++;
    if (obs !== {16'hC000, 4'hC, 4'h0, 4'h0, 8'h00, 4'b1000}) begin
      nFail++;
      $display("FAIL first_write got %h want %h", obs,
               {16'hC000, 4'hC, 4'h0, 4'h0, 8'h00, 4'b1000});
    end
`ifdef IR_VALID_EN
    nTests++;
    if (bus.Valid !== 1'b1) begin
      nFail++;
      $display("FAIL valid_after_write got %b want 1", bus.Valid);
    end
`endif
  endtask

  initial begin
    nTests        = 0;
    nFail         = 0;
    Reset         = 1'b1;
    bus.InstWrite = 1'b0;
    bus.DataIn    = 16'h0000;
    #1;
    test_reset;
    test_load;
    test_hold;
    test_back_to_back;
    test_non_strobe;
    test_reset_vs_write;
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/instruction_register.md
Name: instruction_register

Overview:
- 16-bit instruction register for the processor datapath.
- Loads the fetched instruction word when InstWrite is asserted and holds it otherwise.
- Exposes the raw word plus decoded fields (opcode, destination register, source register, immediate) and four one-hot-style control strobes for the A/B accumulator move and clear operations.
- Sits between instruction memory and the control unit / register file.

Parameters:
- MOVEA_OP, 4'hC, opcode value that asserts MoveA
- MOVEB_OP, 4'hD, opcode value that asserts MoveB
- CLRA_OP, 4'hE, opcode value that asserts CLRA
- CLRB_OP, 4'hF, opcode value that asserts CLRB
- Constraint: all four parameter values must be distinct and nonzero.

Ports:
- CLK  input  1  system clock, rising-edge active
- Reset  input  1  synchronous, active-high reset
- DataIn  input  16  instruction word from memory
- InstWrite  input  1  load enable
- DataOut  output  16  stored instruction word
- Op  output  4  DataOut[15:12]
- Rd  output  4  DataOut[11:8]
- Rm  output  4  DataOut[7:4]
- Imm  output  8  DataOut[7:0] (overlaps Rm by format)
- MoveA  output  1  high when Op == MOVEA_OP
- MoveB  output  1  high when Op == MOVEB_OP
- CLRA  output  1  high when Op == CLRA_OP
- CLRB  output  1  high when Op == CLRB_OP

Behaviour:
- One 16-bit state register IR; all state updates occur on the rising CLK edge only. This is the block's single clock and synchronous active-high reset.
- Priority at each edge:
  - Reset=1: IR <= 16'h0000, regardless of InstWrite.
  - Otherwise InstWrite=1: IR <= DataIn.
  - Otherwise: IR holds its value.
- Load latency: one cycle. DataIn sampled at edge N is visible on all outputs immediately after edge N.
- Outputs are purely combinational from IR (no additional pipeline stage). DataOut = IR.
- Field slicing is fixed as listed under Ports and is independent of opcode.
- Strobe decode:
  - Each strobe is an equality compare of Op against its parameter.
  - At most one strobe is high at a time, because the parameters are distinct.
  - Any other opcode leaves all four strobes low.
- Reset values: IR=0, so DataOut=0, Op=Rd=Rm=0, Imm=0, and all strobes 0 (parameters are nonzero).
- Boundary conditions:
  - DataIn changing while InstWrite=0 has no effect.
  - Back-to-back writes load on every cycle.
  - Reset asserted in the same cycle as InstWrite: reset wins.
  - Reset deasserted: IR stays 0 until the next write.
- Before the first reset, IR is undefined in simulation; no power-on value is required.

Optional Feature:
- Macro: IR_VALID_EN
- Defined:
  - Adds output port Valid (1 bit) and a Valid flag register.
  - Valid is cleared by Reset and set on the first edge where InstWrite=1; once set it stays set until Reset.
  - While Valid=0, MoveA, MoveB, CLRA and CLRB are forced low.
- Undefined: no Valid port or register; strobes depend only on Op.

Test Plan:
- Reset: Reset=1 for 2 cycles with InstWrite=1, DataIn=16'hFFFF -> DataOut=0, Op/Rd/Rm=0, Imm=0, all strobes 0.
- Load: InstWrite=1, DataIn=16'hF0F0 for one edge -> DataOut=F0F0, Op=F, Rd=0, Rm=F, Imm=F0, CLRB=1, other strobes 0.
- Hold: next cycle InstWrite=0, DataIn=16'hCCCA -> DataOut stays F0F0 and CLRB stays 1 for 5 cycles.
- Reload: InstWrite=1, DataIn=16'hCCCA -> Op=C, Rd=C, Rm=C, Imm=CA, MoveA=1, others 0. Then load 16'hD123 -> MoveB=1, Rd=1, Rm=2, Imm=23. Then load 16'hE000 -> CLRA=1.
- Non-strobe opcode: load 16'h5A3C -> Op=5, Rd=A, Rm=3, Imm=3C, all strobes 0.
- Reset vs write: Reset=1 and InstWrite=1 with DataIn=16'hC000 in the same cycle -> DataOut=0 and MoveA=0. With IR_VALID_EN defined, Valid=0 after reset and becomes 1 after the first write.
